mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
- Owns the single byte-wide RAM/IO port of the core and shares it between two requesters: the instruction fetcher and the load/store buffer (LSB).
- Turns each word, half or byte request into a sequence of byte accesses.
- Arbitrates between the two requesters round-robin.
- Aborts speculative reads on pipeline flush.
- Sits between the fetch/LSB front ends and the top-level memory pins.

Parameters:
- ADDR_W, 32, address width.
- IO_HI, 2'b11, value of addr[17:16] that marks the IO region.

Ports:
- clk_in  in  1  system clock
- rst_in  in  1  reset, asynchronous, active-low
- rdy_in  in  1  global ready; pause when low
- rob_clear_up  in  1  pipeline flush from ROB
- if_req  in  1  fetch request, level, held until if_ready
- if_addr  in  32  fetch address
- if_ready  out  1  one-cycle pulse, if_data valid
- if_data  out  32  fetched word, little-endian
- ls_req  in  1  LSB request, level, held until ls_ready
- ls_wr  in  1  1 = store, 0 = load
- ls_size  in  2  00 byte, 01 half, 10 word
- ls_addr  in  32  access address
- ls_wdata  in  32  store data, low bytes used
- ls_ready  out  1  one-cycle pulse, load data valid or store done
- ls_rdata  out  32  load data, zero-extended
- mem_din  in  8  RAM read byte, for the address driven in the previous cycle
- mem_dout  out  8  RAM write byte
- mem_a  out  32  RAM byte address
- mem_wr  out  1  RAM write enable
- io_buffer_full  in  1  UART buffer full

Behaviour:
- Reset (rst_in low, async):
  - state = IDLE, cnt = 0, last_grant = LS.
  - Outputs: if_ready = 0, ls_ready = 0, if_data = 0, ls_rdata = 0, mem_a = 0, mem_dout = 0, mem_wr = 0.
  - Reset mid-transaction abandons it with no ready pulse.
- rdy_in low: every register holds. mem_wr is gated to 0 combinationally. The current byte is replayed on resume.
- States: IDLE, IF_RD, LS_RD, LS_WR. N = 4 for fetch; N = 1, 2 or 4 from ls_size.
- IDLE grant rules:
  - A requester is eligible if its req is high and its own ready output is low in that cycle. This stops a duplicate grant in the pulse cycle.
  - A store to the IO region (ls_addr[17:16] == IO_HI) is ineligible while io_buffer_full is high.
  - If both are eligible, grant the one that is not last_grant. Update last_grant on every grant.
- On grant (edge E0):
  - Latch the address, N and the store data.
  - mem_a <= addr, cnt <= 1.
  - For a store: mem_wr <= 1, mem_dout <= byte0.
- Reads (IF_RD / LS_RD):
  - Each edge, mem_a <= base + cnt while cnt < N; mem_wr = 0.
  - The byte for address k is captured from mem_din at edge E(k+1) into lane k.
  - At the edge that captures byte N-1: drive the data out, pulse the ready output for one cycle, return to IDLE.
  - Ready is high in the cycle after edge EN. Fetch: 5 cycles after the request is sampled.
- Writes (LS_WR):
  - Bytes 1..N-1 are driven on edges E1..E(N-1).
  - At EN: mem_wr <= 0, ls_ready pulses, return to IDLE.
- Address arithmetic is 32-bit wrapping. No alignment check.
- rob_clear_up high at an edge (rdy_in high):
  - In IF_RD or LS_RD: go to IDLE, mem_a and mem_wr are unchanged, no ready pulse.
  - In LS_WR: continue. Stores are committed and non-speculative.
  - Requests are not granted on a clear edge.
  - A ready pulse coinciding with the clear cycle is still emitted. The requester discards it.
- Data outputs hold their value until the next completion.

Decomposition:
- Shared const package:
  - state encoding (IDLE, IF_RD, LS_RD, LS_WR)
  - size encodings (SZ_B, SZ_H, SZ_W)
  - IO_HI region constant
  - requester id (GNT_IF, GNT_LS)
- One sub-module: mem_byte_lane. It does byte select for the store path (wdata, cnt → mem_dout) and byte insert for the read assembly (cnt, mem_din → 32-bit accumulator). The top keeps the FSM and arbitration.

Test Plan:
- Fetch of if_addr = 0x100, RAM bytes 13 05 00 00 → if_data = 0x00000513. if_ready pulses exactly once, 5 cycles after the request. mem_a steps 0x100..0x103.
- if_req and ls_req (load word 0x200) raised together from reset → fetch granted first, the load starts in the IDLE cycle after if_ready. A second simultaneous pair → LS granted first.
- Store half 0xBEEF to 0x30000 with io_buffer_full = 1 for 6 cycles → no mem_wr during the stall. A pending fetch is served meanwhile. Afterwards mem_wr = 1 for 2 cycles with EF@0x30000, BE@0x30001, then ls_ready pulses.
- rob_clear_up in the third cycle of a fetch → no if_ready, state returns to IDLE. A new fetch to 0x400 is granted next and completes. The same flush during a store word does not stop it: 4 write cycles, then ls_ready.
- rdy_in low for 3 cycles in the middle of a load byte at 0x2001 → mem_wr stays 0, registers freeze. ls_rdata = 0x000000XX, correct after resume.
- rst_in pulsed low asynchronously mid-store → all outputs are 0 immediately, no ls_ready. The next request starts cleanly with fetch priority.

Source files
------------

// File: rtl/mem_arbiter_pkg.sv
// Shared constants for the byte-wide memory arbiter: FSM states, access
// size codes, the IO region tag and requester identifiers.
package mem_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_IF_RD = 2'd1,
        ST_LS_RD = 2'd2,
        ST_LS_WR = 2'd3
    } arb_state_e;

    localparam logic [1:0] SZ_B = 2'b00;
    localparam logic [1:0] SZ_H = 2'b01;
    localparam logic [1:0] SZ_W = 2'b10;

    // addr[17:16] value that selects the memory-mapped IO window
    localparam logic [1:0] IO_REGION_HI = 2'b11;

    typedef enum logic {
        GNT_IF = 1'b0,
        GNT_LS = 1'b1
    } gnt_e;

    // Number of byte beats for an LSB access size; unused code 11 behaves as a word
    function automatic logic [2:0] size_to_len(input logic [1:0] sz);
        case (sz)
            SZ_B:    return 3'd1;
            SZ_H:    return 3'd2;
            default: return 3'd4;
        endcase
    endfunction

endpackage

// File: rtl/mem_byte_lane.sv
// Byte lane steering: picks the outgoing store byte and merges an incoming
// read byte into the 32-bit little-endian assembly word.
module mem_byte_lane
    import mem_arbiter_pkg::*;
(
    input  logic [31:0] wdata_i,
    input  logic [1:0]  wsel_i,
    output logic [7:0]  wbyte_o,
    input  logic [31:0] acc_i,
    input  logic [1:0]  rsel_i,
    input  logic [7:0]  din_i,
    output logic [31:0] acc_o
);

    // Store path: select byte wsel_i of the store word
    always_comb begin
        case (wsel_i)
            2'd0:    wbyte_o = wdata_i[7:0];
            2'd1:    wbyte_o = wdata_i[15:8];
            2'd2:    wbyte_o = wdata_i[23:16];
            default: wbyte_o = wdata_i[31:24];
        endcase
    end

    // Read path: overwrite lane rsel_i of the accumulator with the RAM byte
    always_comb begin
        acc_o = acc_i;
        case (rsel_i)
            2'd0:    acc_o[7:0]   = din_i;
            2'd1:    acc_o[15:8]  = din_i;
            2'd2:    acc_o[23:16] = din_i;
            default: acc_o[31:24] = din_i;
        endcase
    end

endmodule

// File: rtl/mem_arbiter.sv
// Shares the single byte-wide RAM/IO port between instruction fetch and the
// load/store buffer. Each request becomes 1, 2 or 4 byte beats; requesters
// alternate when both are waiting, and speculative reads abort on flush.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int         ADDR_W = 32,
    parameter logic [1:0] IO_HI  = IO_REGION_HI
) (
    input  logic              clk_in,
    input  logic              rst_in,
    input  logic              rdy_in,
    input  logic              rob_clear_up,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_ready,
    output logic [31:0]       if_data,
    input  logic              ls_req,
    input  logic              ls_wr,
    input  logic [1:0]        ls_size,
    input  logic [ADDR_W-1:0] ls_addr,
    input  logic [31:0]       ls_wdata,
    output logic              ls_ready,
    output logic [31:0]       ls_rdata,
    input  logic [7:0]        mem_din,
    output logic [7:0]        mem_dout,
    output logic [ADDR_W-1:0] mem_a,
    output logic              mem_wr,
    input  logic              io_buffer_full
);

    arb_state_e        state_q, state_d;
    gnt_e              last_q, last_d;
    logic [2:0]        cnt_q, cnt_d;
    logic [2:0]        len_q, len_d;
    logic [ADDR_W-1:0] base_q, base_d;
    logic [ADDR_W-1:0] mem_a_q, mem_a_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [31:0]       acc_q, acc_d;
    logic [31:0]       if_data_q, if_data_d;
    logic [31:0]       ls_rdata_q, ls_rdata_d;
    logic [7:0]        mem_dout_q, mem_dout_d;
    logic              mem_wr_q, mem_wr_d;
    logic              if_ready_q, if_ready_d;
    logic              ls_ready_q, ls_ready_d;

    logic              if_elig, ls_elig, ls_io_block;
    logic              grant_if, grant_ls;
    logic              last_beat;
    logic [ADDR_W-1:0] next_addr;
    logic [31:0]       lane_wdata, acc_ins;
    logic [1:0]        lane_wsel, lane_rsel;
    logic [7:0]        lane_wbyte;

    // A requester whose ready pulse is still high has already been served.
    assign if_elig     = if_req && !if_ready_q;
    assign ls_io_block = ls_wr && (ls_addr[17:16] == IO_HI) && io_buffer_full;
    assign ls_elig     = ls_req && !ls_ready_q && !ls_io_block;
    assign grant_if    = if_elig && (!ls_elig || (last_q == GNT_LS));
    assign grant_ls    = ls_elig && (!if_elig || (last_q == GNT_IF));

    assign last_beat = (cnt_q == len_q);
    assign next_addr = base_q + ADDR_W'(cnt_q);

    // Byte 0 of a store leaves on the grant edge, straight from the request port.
    assign lane_wdata = (state_q == ST_IDLE) ? ls_wdata : wdata_q;
    assign lane_wsel  = (state_q == ST_IDLE) ? 2'd0 : cnt_q[1:0];
    assign lane_rsel  = cnt_q[1:0] - 2'd1;

    mem_byte_lane u_lane (
        .wdata_i (lane_wdata),
        .wsel_i  (lane_wsel),
        .wbyte_o (lane_wbyte),
        .acc_i   (acc_q),
        .rsel_i  (lane_rsel),
        .din_i   (mem_din),
        .acc_o   (acc_ins)
    );

    // Next-state logic: arbitration in IDLE, byte sequencing in the access states
    always_comb begin
        state_d    = state_q;
        last_d     = last_q;
        cnt_d      = cnt_q;
        len_d      = len_q;
        base_d     = base_q;
        mem_a_d    = mem_a_q;
        wdata_d    = wdata_q;
        acc_d      = acc_q;
        if_data_d  = if_data_q;
        ls_rdata_d = ls_rdata_q;
        mem_dout_d = mem_dout_q;
        mem_wr_d   = mem_wr_q;
        if_ready_d = 1'b0;
        ls_ready_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!rob_clear_up) begin
                    if (grant_if) begin
                        state_d = ST_IF_RD;
                        last_d  = GNT_IF;
                        base_d  = if_addr;
                        mem_a_d = if_addr;
                        len_d   = 3'd4;
                        cnt_d   = 3'd1;
                        acc_d   = '0;
                    end else if (grant_ls) begin
                        last_d  = GNT_LS;
                        base_d  = ls_addr;
                        mem_a_d = ls_addr;
                        len_d   = size_to_len(ls_size);
                        cnt_d   = 3'd1;
                        acc_d   = '0;
                        wdata_d = ls_wdata;
                        if (ls_wr) begin
                            state_d    = ST_LS_WR;
                            mem_wr_d   = 1'b1;
                            mem_dout_d = lane_wbyte;
                        end else begin
                            state_d = ST_LS_RD;
                        end
                    end
                end
            end
            ST_IF_RD, ST_LS_RD: begin
                if (rob_clear_up) begin
                    state_d = ST_IDLE;
                end else begin
                    acc_d = acc_ins;
                    if (last_beat) begin
                        state_d = ST_IDLE;
                        if (state_q == ST_IF_RD) begin
                            if_data_d  = acc_ins;
                            if_ready_d = 1'b1;
                        end else begin
                            ls_rdata_d = acc_ins;
                            ls_ready_d = 1'b1;
                        end
                    end else begin
                        mem_a_d = next_addr;
                        cnt_d   = cnt_q + 3'd1;
                    end
                end
            end
            default: begin
                // Stores are committed, so a flush does not interrupt them.
                if (last_beat) begin
                    state_d    = ST_IDLE;
                    mem_wr_d   = 1'b0;
                    ls_ready_d = 1'b1;
                end else begin
                    mem_a_d    = next_addr;
                    mem_dout_d = lane_wbyte;
                    cnt_d      = cnt_q + 3'd1;
                end
            end
        endcase
    end

    // State and registered outputs; everything freezes while rdy_in is low
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state_q    <= ST_IDLE;
            last_q     <= GNT_LS;
            cnt_q      <= '0;
            len_q      <= '0;
            base_q     <= '0;
            mem_a_q    <= '0;
            wdata_q    <= '0;
            acc_q      <= '0;
            if_data_q  <= '0;
            ls_rdata_q <= '0;
            mem_dout_q <= '0;
            mem_wr_q   <= 1'b0;
            if_ready_q <= 1'b0;
            ls_ready_q <= 1'b0;
        end else if (rdy_in) begin
            state_q    <= state_d;
            last_q     <= last_d;
            cnt_q      <= cnt_d;
            len_q      <= len_d;
            base_q     <= base_d;
            mem_a_q    <= mem_a_d;
            wdata_q    <= wdata_d;
            acc_q      <= acc_d;
            if_data_q  <= if_data_d;
            ls_rdata_q <= ls_rdata_d;
            mem_dout_q <= mem_dout_d;
            mem_wr_q   <= mem_wr_d;
            if_ready_q <= if_ready_d;
            ls_ready_q <= ls_ready_d;
        end
    end

    assign if_ready = if_ready_q;
    assign ls_ready = ls_ready_q;
    assign if_data  = if_data_q;
    assign ls_rdata = ls_rdata_q;
    assign mem_a    = mem_a_q;
    assign mem_dout = mem_dout_q;
    // A paused cycle must never write, even mid-store.
    assign mem_wr   = mem_wr_q & rdy_in;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: a byte RAM model, expected-transaction
// queues filled from the access rules, and a per-cycle compare process.
module tb_mem_arbiter;

    typedef struct packed {
        logic [31:0] a;
        logic [7:0]  d;
    } wr_t;

    logic        clk = 1'b0;
    logic        rst_in = 1'b0;
    logic        rdy_in = 1'b1;
    logic        rob_clear_up = 1'b0;
    logic        if_req = 1'b0;
    logic [31:0] if_addr = '0;
    logic        if_ready;
    logic [31:0] if_data;
    logic        ls_req = 1'b0;
    logic        ls_wr = 1'b0;
    logic [1:0]  ls_size = 2'b00;
    logic [31:0] ls_addr = '0;
    logic [31:0] ls_wdata = '0;
    logic        ls_ready;
    logic [31:0] ls_rdata;
    logic [7:0]  mem_din;
    logic [7:0]  mem_dout;
    logic [31:0] mem_a;
    logic        mem_wr;
    logic        io_buffer_full = 1'b0;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int if_pulses = 0;
    int ls_pulses = 0;
    int wr_cnt = 0;

    logic [7:0]  ram [0:262143];
    logic [31:0] exp_if[$];
    logic [31:0] exp_ls[$];
    wr_t         exp_wr[$];

    mem_arbiter dut (
        .clk_in         (clk),
        .rst_in         (rst_in),
        .rdy_in         (rdy_in),
        .rob_clear_up   (rob_clear_up),
        .if_req         (if_req),
        .if_addr        (if_addr),
        .if_ready       (if_ready),
        .if_data        (if_data),
        .ls_req         (ls_req),
        .ls_wr          (ls_wr),
        .ls_size        (ls_size),
        .ls_addr        (ls_addr),
        .ls_wdata       (ls_wdata),
        .ls_ready       (ls_ready),
        .ls_rdata       (ls_rdata),
        .mem_din        (mem_din),
        .mem_dout       (mem_dout),
        .mem_a          (mem_a),
        .mem_wr         (mem_wr),
        .io_buffer_full (io_buffer_full)
    );

    always #5 clk = ~clk;

    // RAM presents the byte for the currently driven address; writes land on the edge.
    assign mem_din = ram[mem_a[17:0]];
    always @(posedge clk) begin
        cyc = cyc + 1;
        if (mem_wr) ram[mem_a[17:0]] = mem_dout;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    // Little-endian, zero-extended read of n bytes with 32-bit wrapping addresses.
    function automatic logic [31:0] model_read(input logic [31:0] a, input int n);
        logic [31:0] v;
        logic [31:0] ai;
        v = '0;
        for (int i = 0; i < n; i++) begin
            ai = a + 32'(i);
            v[8*i +: 8] = ram[ai[17:0]];
        end
        return v;
    endfunction

    // Per-cycle compare against the expected transaction queues.
    always @(negedge clk) begin
        if (rst_in) begin
            if (!rdy_in) chk("wr_gated_when_paused", {31'd0, mem_wr}, 32'd0);
            if (if_ready) begin
                if_pulses++;
                if (exp_if.size() == 0) chk("if_ready_unexpected", 32'd1, 32'd0);
                else chk("if_data", if_data, exp_if.pop_front());
            end
            if (ls_ready) begin
                ls_pulses++;
                if (exp_ls.size() != 0) chk("ls_rdata", ls_rdata, exp_ls.pop_front());
            end
            if (mem_wr) begin
                wr_t e;
                wr_cnt++;
                if (exp_wr.size() == 0) begin
                    chk("mem_wr_unexpected", mem_a, 32'hFFFF_FFFF);
                end else begin
                    e = exp_wr.pop_front();
                    chk("wr_addr", mem_a, e.a);
                    chk("wr_byte", {24'd0, mem_dout}, {24'd0, e.d});
                end
            end
        end
    end

    task automatic fetch(input logic [31:0] a, input int exp_lat);
        int c0, lat;
        exp_if.push_back(model_read(a, 4));
        if_addr = a;
        if_req  = 1'b1;
        c0  = cyc;
        lat = -1;
        for (int k = 0; k < 40 && lat < 0; k++) begin
            step();
            if (if_ready) lat = cyc - c0;
        end
        if_req = 1'b0;
        chk("if_latency", lat, exp_lat);
    endtask

    task automatic lsop(input bit wr, input logic [1:0] sz, input logic [31:0] a,
                        input logic [31:0] wd, input int exp_lat);
        int c0, lat, n, lsp;
        wr_t e;
        n = (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
        if (wr) begin
            for (int i = 0; i < n; i++) begin
                e.a = a + 32'(i);
                e.d = wd[8*i +: 8];
                exp_wr.push_back(e);
            end
        end else begin
            exp_ls.push_back(model_read(a, n));
        end
        ls_wr = wr; ls_size = sz; ls_addr = a; ls_wdata = wd; ls_req = 1'b1;
        c0  = cyc;
        lsp = exp_ls.size();
        lat = -1;
        for (int k = 0; k < 40 && lat < 0; k++) begin
            step();
            if (ls_ready) lat = cyc - c0;
        end
        ls_req = 1'b0;
        chk("ls_latency", lat, exp_lat);
        if (lsp < 0) chk("ls_queue", lsp, 0);
    endtask

    task automatic do_reset();
        rst_in = 1'b0;
        step();
        step();
        rst_in = 1'b1;
        step();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int p0, w0;
        for (int i = 0; i < 262144; i++) ram[i] = 8'(i * 7 + 3);
        ram[18'h100] = 8'h13; ram[18'h101] = 8'h05; ram[18'h102] = 8'h00; ram[18'h103] = 8'h00;
        ram[18'h2001] = 8'h5A;
        ram[18'h3FFFF] = 8'h34; ram[18'h0] = 8'h12;

        // Reset state
        step();
        step();
        chk("rst_if_ready", {31'd0, if_ready}, 32'd0);
        chk("rst_ls_ready", {31'd0, ls_ready}, 32'd0);
        chk("rst_if_data", if_data, 32'd0);
        chk("rst_ls_rdata", ls_rdata, 32'd0);
        chk("rst_mem_a", mem_a, 32'd0);
        chk("rst_mem_dout", {24'd0, mem_dout}, 32'd0);
        chk("rst_mem_wr", {31'd0, mem_wr}, 32'd0);
        rst_in = 1'b1;
        step();

        // Single fetch at 0x100: address walk, data and one pulse
        p0 = if_pulses;
        fork
            fetch(32'h100, 5);
            begin
                for (int k = 0; k < 4; k++) begin
                    step();
                    chk("fetch_mem_a", mem_a, 32'h100 + 32'(k));
                end
            end
        join
        chk("fetch_data_lit", if_data, 32'h0000_0513);
        step(); step(); step();
        chk("fetch_one_pulse", if_pulses - p0, 1);

        // Simultaneous pair from reset: fetch first, then load
        do_reset();
        fork
            fetch(32'h104, 5);
            lsop(1'b0, 2'b10, 32'h200, 32'h0, 10);
        join
        step();
        // Solo fetch, then a pair: load now wins
        fetch(32'h108, 5);
        step();
        fork
            fetch(32'h10C, 10);
            lsop(1'b0, 2'b10, 32'h204, 32'h0, 5);
        join
        step();

        // IO store stalled by full buffer while a fetch proceeds
        w0 = wr_cnt;
        io_buffer_full = 1'b1;
        fork
            fetch(32'h104, 5);
            lsop(1'b1, 2'b01, 32'h30000, 32'h0000_BEEF, 9);
            begin
                repeat (6) step();
                chk("io_stall_no_write", wr_cnt - w0, 0);
                io_buffer_full = 1'b0;
            end
        join
        chk("io_store_beats", wr_cnt - w0, 2);
        chk("io_store_ram_lo", {24'd0, ram[18'h30000]}, 32'hEF);
        chk("io_store_ram_hi", {24'd0, ram[18'h30001]}, 32'hBE);
        step();

        // Flush in the third fetch cycle abandons the fetch
        p0 = if_pulses;
        if_addr = 32'h500;
        if_req  = 1'b1;
        step(); step(); step();
        rob_clear_up = 1'b1;
        if_req = 1'b0;
        step();
        rob_clear_up = 1'b0;
        chk("flush_mem_a_held", mem_a, 32'h502);
        repeat (6) step();
        chk("flush_no_pulse", if_pulses - p0, 0);
        fetch(32'h400, 5);
        step();

        // Flush during a store word does not stop it
        w0 = wr_cnt;
        fork
            lsop(1'b1, 2'b10, 32'h600, 32'hDDCC_BBAA, 5);
            begin
                step(); step();
                rob_clear_up = 1'b1;
                step();
                rob_clear_up = 1'b0;
            end
        join
        chk("flush_store_beats", wr_cnt - w0, 4);
        step();

        // Pause during a store byte: write suppressed until resume
        w0 = wr_cnt;
        fork
            lsop(1'b1, 2'b00, 32'h700, 32'h0000_0077, 4);
            begin
                step();
                rdy_in = 1'b0;
                step(); step();
                rdy_in = 1'b1;
            end
        join
        chk("pause_store_beats", wr_cnt - w0, 1);
        step();

        // Pause during a load byte at 0x2001
        fork
            lsop(1'b0, 2'b00, 32'h2001, 32'h0, 5);
            begin
                step();
                rdy_in = 1'b0;
                repeat (3) begin
                    step();
                    chk("pause_mem_a", mem_a, 32'h2001);
                end
                rdy_in = 1'b1;
            end
        join
        chk("load_byte_lit", ls_rdata, 32'h0000_005A);
        step();

        // Half load across the 32-bit address wrap
        fork
            lsop(1'b0, 2'b01, 32'hFFFF_FFFF, 32'h0, 3);
            begin
                step(); step();
                chk("wrap_mem_a", mem_a, 32'h0);
            end
        join
        chk("wrap_half_lit", ls_rdata, 32'h0000_1234);
        step();

        // Asynchronous reset in the middle of a store word
        p0 = ls_pulses;
        ls_wr = 1'b1; ls_size = 2'b10; ls_addr = 32'h800; ls_wdata = 32'h1122_3344;
        for (int i = 0; i < 4; i++) begin
            wr_t e;
            e.a = 32'h800 + 32'(i);
            e.d = ls_wdata[8*i +: 8];
            exp_wr.push_back(e);
        end
        ls_req = 1'b1;
        step(); step();
        #1;
        rst_in = 1'b0;
        #1;
        chk("arst_mem_wr", {31'd0, mem_wr}, 32'd0);
        chk("arst_mem_a", mem_a, 32'd0);
        chk("arst_mem_dout", {24'd0, mem_dout}, 32'd0);
        chk("arst_ls_ready", {31'd0, ls_ready}, 32'd0);
        chk("arst_if_data", if_data, 32'd0);
        chk("arst_ls_rdata", ls_rdata, 32'd0);
        ls_req = 1'b0;
        exp_wr.delete();
        step(); step();
        rst_in = 1'b1;
        repeat (4) step();
        chk("arst_no_ls_pulse", ls_pulses - p0, 0);
        fork
            fetch(32'h104, 5);
            lsop(1'b0, 2'b10, 32'h200, 32'h0, 10);
        join
        step(); step();
        chk("queues_drained", exp_if.size() + exp_ls.size() + exp_wr.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
